// File: rtl/stoch_signed_nmax_sel_if.sv
// Bus for the signed stochastic max/min selector: control, channel bitstreams, forwarded pair.
// With STOCH_NMAX_ARGMAX_EN defined, the bus also carries argmax and sel_valid.
interface stoch_signed_nmax_sel_if #(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
);
    logic                  clear;
    logic                  mode;
    logic [NUM_INPUTS-1:0] as_p;
    logic [NUM_INPUTS-1:0] as_m;
    logic                  y_p;
    logic                  y_m;
`ifdef STOCH_NMAX_ARGMAX_EN
    logic [SEL_W-1:0]      argmax;
    logic                  sel_valid;

    modport master (output clear, mode, as_p, as_m, input y_p, y_m, argmax, sel_valid);
    modport slave  (input clear, mode, as_p, as_m, output y_p, y_m, argmax, sel_valid);
`else
    modport master (output clear, mode, as_p, as_m, input y_p, y_m);
    modport slave  (input clear, mode, as_p, as_m, output y_p, y_m);
`endif
endinterface

// File: rtl/stoch_signed_nmax_sel.sv
// N-channel signed stochastic max/min selector: one rescaling accumulator per channel, hysteretic winner.
// Optional STOCH_NMAX_ARGMAX_EN adds argmax/sel_valid outputs on the bus.
module stoch_nmax_lane #(
    parameter int COUNTER_SIZE = 8
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           i_clear,
    input  logic                           i_p,
    input  logic                           i_m,
    input  logic                           i_rescale,
    output logic signed [COUNTER_SIZE-1:0] o_cnt,
    output logic                           o_ovf
);
    localparam int C = COUNTER_SIZE;

    logic signed [C-1:0] r_cnt;
    logic signed [C:0]   w_delta;
    logic signed [C:0]   w_nxt;

    always_comb begin
        w_delta = '0;
        if (i_p && !i_m)
            w_delta = {{C{1'b0}}, 1'b1};
        else if (!i_p && i_m)
            w_delta = '1;
    end

    assign w_nxt = {r_cnt[C-1], r_cnt} + w_delta;
    // Out of range when the extra sign bit disagrees with the C-bit sign.
    assign o_ovf = w_nxt[C] ^ w_nxt[C-1];
    assign o_cnt = r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_rescale)
            r_cnt <= w_nxt[C:1];
        else
            r_cnt <= w_nxt[C-1:0];
    end
endmodule

module stoch_signed_nmax_sel #(
    parameter int COUNTER_SIZE = 8,
    parameter int NUM_INPUTS   = 4,
    parameter int SEL_W        = $clog2(NUM_INPUTS)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    stoch_signed_nmax_sel_if.slave   bus
);
    localparam int C = COUNTER_SIZE;

    logic [NUM_INPUTS-1:0][C-1:0] w_cnt;
    logic [NUM_INPUTS-1:0]        w_ovf;
    logic                         w_rescale;
    logic [SEL_W-1:0]             w_cand;
    logic                         w_beat;
    logic [SEL_W-1:0]             r_sel;
    logic                         r_y_p;
    logic                         r_y_m;

    // A single overflowing lane halves every lane so relative order survives.
    assign w_rescale = |w_ovf;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
        stoch_nmax_lane #(.COUNTER_SIZE(C)) u_lane (
            .CLK       (CLK),
            .nRST      (nRST),
            .i_clear   (bus.clear),
            .i_p       (bus.as_p[g]),
            .i_m       (bus.as_m[g]),
            .i_rescale (w_rescale),
            .o_cnt     (w_cnt[g]),
            .o_ovf     (w_ovf[g])
        );
    end

    // Strict comparison keeps the lowest index on ties.
    always_comb begin
        w_cand = '0;
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (bus.mode ? ($signed(w_cnt[i]) < $signed(w_cnt[w_cand]))
                         : ($signed(w_cnt[i]) > $signed(w_cnt[w_cand])))
                w_cand = SEL_W'(i);
        end
    end

    assign w_beat = bus.mode ? ($signed(w_cnt[w_cand]) < $signed(w_cnt[r_sel]))
                             : ($signed(w_cnt[w_cand]) > $signed(w_cnt[r_sel]));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sel <= '0;
            r_y_p <= 1'b0;
            r_y_m <= 1'b0;
        end else if (bus.clear) begin
            r_sel <= '0;
            r_y_p <= 1'b0;
            r_y_m <= 1'b0;
        end else begin
            r_y_p <= bus.as_p[r_sel];
            r_y_m <= bus.as_m[r_sel];
            if (w_beat)
                r_sel <= w_cand;
        end
    end

    assign bus.y_p = r_y_p;
    assign bus.y_m = r_y_m;

`ifdef STOCH_NMAX_ARGMAX_EN
    logic r_valid;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_valid <= 1'b0;
        else if (bus.clear)
            r_valid <= 1'b0;
        else
            r_valid <= r_valid | (|(bus.as_p ^ bus.as_m));
    end

    assign bus.argmax    = r_sel;
    assign bus.sel_valid = r_valid;
`endif
endmodule

// File: tb/tb_stoch_signed_nmax_sel.sv
// Directed bench for stoch_signed_nmax_sel: an N=4/C=8 instance and an N=4/C=4 instance for rescale.
// The winner is observed through zero-delta probes (as_p = as_m = one-hot of the expected index).
module tb_stoch_signed_nmax_sel;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    stoch_signed_nmax_sel_if #(.NUM_INPUTS(4)) bus ();
    stoch_signed_nmax_sel_if #(.NUM_INPUTS(4)) bus4 ();

    stoch_signed_nmax_sel #(.COUNTER_SIZE(8), .NUM_INPUTS(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    stoch_signed_nmax_sel #(.COUNTER_SIZE(4), .NUM_INPUTS(4)) dut4 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] p, input logic [3:0] m);
        bus.as_p = p;
        bus.as_m = m;
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc4(input logic [3:0] p, input logic [3:0] m);
        bus4.as_p = p;
        bus4.as_m = m;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_sel(input string tag, input int s);
        logic [3:0] oh;
        oh = 4'(1 << s);
        cyc(oh, oh);
        chk(tag, {bus.y_p, bus.y_m}, 2'b11);
    endtask

    task automatic chk_sel4(input string tag, input int s);
        logic [3:0] oh;
        oh = 4'(1 << s);
        cyc4(oh, oh);
        chk(tag, {bus4.y_p, bus4.y_m}, 2'b11);
    endtask

    task automatic do_reset();
        bus.clear = 1'b0;  bus.mode = 1'b0;  bus.as_p = '0;  bus.as_m = '0;
        bus4.clear = 1'b0; bus4.mode = 1'b0; bus4.as_p = '0; bus4.as_m = '0;
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_y", {bus.y_p, bus.y_m}, 2'b00);
`ifdef STOCH_NMAX_ARGMAX_EN
        chk("rst_valid", bus.sel_valid, 1'b0);
        chk("rst_argmax", bus.argmax, 2'd0);
`endif

        // max tracking: ch2 climbs, wins at edge 2, forwarded from edge 3
        cyc(4'b0100, 4'b0000);
        chk("max_e1", {bus.y_p, bus.y_m}, 2'b00);
`ifdef STOCH_NMAX_ARGMAX_EN
        chk("max_valid_e1", bus.sel_valid, 1'b1);
`endif
        cyc(4'b0100, 4'b0000);
        chk("max_e2", {bus.y_p, bus.y_m}, 2'b00);
`ifdef STOCH_NMAX_ARGMAX_EN
        chk("max_argmax_e2", bus.argmax, 2'd2);
`endif
        cyc(4'b0100, 4'b0000);
        chk("max_e3", {bus.y_p, bus.y_m}, 2'b10);
        cyc(4'b0100, 4'b0100);
        chk("max_pair11", {bus.y_p, bus.y_m}, 2'b11);
        cyc(4'b0000, 4'b0100);
        chk("max_neg", {bus.y_p, bus.y_m}, 2'b01);

        // async reset between edges
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_y", {bus.y_p, bus.y_m}, 2'b00);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        chk_sel("async_rst_sel", 0);

        // clear wins over the update in the same cycle
        for (int k = 0; k < 4; k++) cyc(4'b1000, 4'b0000);
        bus.clear = 1'b1;
        cyc(4'b1111, 4'b0000);
        bus.clear = 1'b0;
        chk("clr_y", {bus.y_p, bus.y_m}, 2'b00);
`ifdef STOCH_NMAX_ARGMAX_EN
        chk("clr_valid", bus.sel_valid, 1'b0);
`endif
        chk_sel("clr_sel", 0);
        cyc(4'b0010, 4'b0000);
        chk_sel("clr_cnt_pre", 0);
        chk_sel("clr_cnt_post", 1);

        // tie between ch1 and ch3: lowest index wins and holds
        do_reset();
        for (int k = 0; k < 100; k++) cyc(4'b1010, 4'b0000);
        chk("tie_stream_y", {bus.y_p, bus.y_m}, 2'b10);
        chk_sel("tie_hold", 1);
        cyc(4'b1000, 4'b0000);
        chk_sel("tie_lead_pre", 1);
        chk_sel("tie_lead_post", 3);

        // min mode, then toggle to max mid-stream
        do_reset();
        bus.mode = 1'b1;
        for (int k = 0; k < 3; k++) cyc(4'b1110, 4'b0001);
        chk("min_stream_y", {bus.y_p, bus.y_m}, 2'b01);
        chk_sel("min_sel", 0);
        bus.mode = 1'b0;
        chk_sel("min_toggle_old", 0);
        chk_sel("min_toggle_new", 1);

        // rescale on C=4: ch0 hits +8 at cycle 8, both lanes halve (4 and 2)
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cyc4({2'b00, 1'(k % 2), 1'b1}, 4'b0000);
            chk($sformatf("rs_y_%0d", k), {bus4.y_p, bus4.y_m}, 2'b10);
        end
        cyc4(4'b0010, 4'b0000);
        chk("rs_after_y", {bus4.y_p, bus4.y_m}, 2'b00);
        cyc4(4'b0010, 4'b0000);
        chk_sel4("rs_tie", 0);
        cyc4(4'b0010, 4'b0000);
        chk_sel4("rs_pre", 0);
        chk_sel4("rs_post", 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
